// File: rtl/pc_ctrl.sv
// Program-counter unit for the MIPS fetch stage: sequential fetch, stall hold,
// branch redirect (deferred while stalled), exception flush and target-alignment trap.
module pc_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INC = 4,
  parameter int unsigned ALIGN_BITS = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = ADDR_WIDTH'(32'h0000_0040)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] new_pc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  ce,
  output logic                  misalign,
  output logic [ADDR_WIDTH-1:0] bad_addr
);

  localparam logic ST_BOOT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ce_q, ce_d;
  logic                  misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0] bad_addr_q, bad_addr_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_target_q, pend_target_d;

  logic                  redir_take;
  logic [ADDR_WIDTH-1:0] redir_target;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ce_d          = ce_q;
    misalign_d    = 1'b0;
    bad_addr_d    = bad_addr_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    redir_take    = 1'b0;
    redir_target  = branch_target;

    if (state_q == ST_BOOT) begin
      // First fetch is RESET_VECTOR itself, so pc is not advanced here.
      ce_d    = 1'b1;
      state_d = ST_RUN;
    end else begin
      ce_d = 1'b1;
      if (flush) begin
        pc_d         = new_pc;
        pend_valid_d = 1'b0;
      end else if (branch_flag && !stall) begin
        redir_take   = 1'b1;
        redir_target = branch_target;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q && !stall) begin
        redir_take   = 1'b1;
        redir_target = pend_target_q;
        pend_valid_d = 1'b0;
      end else if (stall) begin
        if (branch_flag) begin
          pend_target_d = branch_target;
          pend_valid_d  = 1'b1;
        end
      end else begin
        pc_d = pc_q + ADDR_WIDTH'(INC);
      end

      // Alignment is checked only when a redirect is actually applied.
      if (redir_take) begin
        if ((redir_target & ALIGN_MASK) != '0) begin
          pc_d       = EXC_VECTOR;
          bad_addr_d = redir_target;
          misalign_d = 1'b1;
        end else begin
          pc_d = redir_target;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_VECTOR;
      ce_q          <= 1'b0;
      misalign_q    <= 1'b0;
      bad_addr_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ce_q          <= ce_d;
      misalign_q    <= misalign_d;
      bad_addr_q    <= bad_addr_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc       = pc_q;
  assign ce       = ce_q;
  assign misalign = misalign_q;
  assign bad_addr = bad_addr_q;

endmodule
